// File: rtl/full_hash_des_sbox_stream_if.sv
// Byte-stream, start-command and digest handshake bundle for full_hash_des_sbox_stream.
// Carries the iv input only when FULL_HASH_IV_LOAD_EN is defined.
interface full_hash_des_sbox_stream_if #(
    parameter int unsigned CNT_W = 64
);
    logic             start;
    logic             start_ready;
    logic [CNT_W-1:0] msg_len;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_ready;
    logic [31:0]      digest_out;
    logic             digest_valid;
    logic             digest_ready;
    logic             busy;
`ifdef FULL_HASH_IV_LOAD_EN
    logic [31:0]      iv;

    modport master (
        output start, msg_len, m_valid, m_data, digest_ready, iv,
        input  start_ready, m_ready, digest_out, digest_valid, busy
    );
    modport slave (
        input  start, msg_len, m_valid, m_data, digest_ready, iv,
        output start_ready, m_ready, digest_out, digest_valid, busy
    );
`else
    modport master (
        output start, msg_len, m_valid, m_data, digest_ready,
        input  start_ready, m_ready, digest_out, digest_valid, busy
    );
    modport slave (
        input  start, msg_len, m_valid, m_data, digest_ready,
        output start_ready, m_ready, digest_out, digest_valid, busy
    );
`endif
endinterface

// File: rtl/full_hash_des_sbox_stream.sv
// Iterative full-hash DES S-box engine: byte stream in, 32-bit digest out under valid/ready.
// FULL_HASH_IV_LOAD_EN: start state is taken from bus.iv instead of the constant vector.
module full_hash_des_sbox_stream #(
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned CNT_W  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    full_hash_des_sbox_stream_if.slave bus
);
    typedef logic [7:0][3:0] hvec_t;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, ROUND, FINAL, OUT} state_e;

    localparam hvec_t       H_INIT  = 32'h4B71DF03;
    localparam int unsigned UNR_S   = (UNROLL == 0) ? 1 : UNROLL;
    localparam int unsigned RC_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS - UNR_S);

    if (ROUNDS < 1) begin : g_err_rounds
        $error("ROUNDS must be at least 1");
    end
    if (UNROLL < 1 || (ROUNDS % UNR_S) != 0) begin : g_err_unroll
        $error("UNROLL must divide ROUNDS");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_err_cnt_w
        $error("CNT_W must be in 1..64");
    end

    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
        logic [3:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = {x[2:0], x[3]};
            2'd2:    r = {x[1:0], x[3:2]};
            default: r = {x[0], x[3:1]};
        endcase
        return r;
    endfunction

    // DES S5: row = {a5,a0}, column = a[4:1]; each row packs column 0 in the top nibble
    function automatic logic [3:0] s_box(input logic [5:0] a);
        logic [63:0] row;
        case ({a[5], a[0]})
            2'd0:    row = 64'h2C417AB6853FD0E9;
            2'd1:    row = 64'hEB2C47D150FA3986;
            2'd2:    row = 64'h421BAD78F9C5630E;
            default: row = 64'hB8C71E2D6F09A453;
        endcase
        return row[{~a[4:1], 2'b00} +: 4];
    endfunction

    function automatic logic [5:0] msg_to_m6(input logic [7:0] m);
        return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
    endfunction

    function automatic logic [5:0] counter_to_c6(input logic [7:0] c);
        return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
    endfunction

    function automatic hvec_t round_fn(input hvec_t h, input logic [3:0] s);
        hvec_t o;
        for (int unsigned i = 0; i < 8; i++)
            o[3'(i)] = rotl4(h[3'(i + 1)] ^ s, 2'(i >> 1));
        return o;
    endfunction

    function automatic hvec_t final_fn(input hvec_t h, input logic [7:0][7:0] len);
        hvec_t o;
        for (int unsigned i = 0; i < 8; i++)
            o[3'(i)] = rotl4(h[3'(i + 1)] ^ s_box(counter_to_c6(len[3'(i)])), 2'(i >> 1));
        return o;
    endfunction

    state_e           state_q, state_d;
    hvec_t            h_q, h_d;
    hvec_t            dig_q, dig_d;
    logic             dv_q, dv_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [RC_W-1:0]  rnd_q, rnd_d;

    logic [3:0] s_msg;
    hvec_t      h_round;

    // The byte's S-box value is identical for all of its rounds, so one lookup feeds the chain
    assign s_msg = s_box(msg_to_m6(byte_q));

    always_comb begin
        h_round = h_q;
        for (int unsigned k = 0; k < UNR_S; k++)
            h_round = round_fn(h_round, s_msg);
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        dig_d   = dig_q;
        dv_d    = dv_q;
        byte_d  = byte_q;
        rem_d   = rem_q;
        len_d   = len_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef FULL_HASH_IV_LOAD_EN
                    h_d = bus.iv;
`else
                    h_d = H_INIT;
`endif
                    rem_d   = bus.msg_len;
                    len_d   = bus.msg_len;
                    state_d = (bus.msg_len != '0) ? WAIT_BYTE : FINAL;
                end
            end
            WAIT_BYTE: begin
                if (bus.m_valid) begin
                    byte_d  = bus.m_data;
                    rnd_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                h_d = h_round;
                if (rnd_q == RC_LAST) begin
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? FINAL : WAIT_BYTE;
                end else begin
                    rnd_d = rnd_q + RC_W'(UNR_S);
                end
            end
            FINAL: begin
                dig_d   = final_fn(h_q, 64'(len_q));
                dv_d    = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (bus.digest_ready) begin
                    dv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= H_INIT;
            dig_q   <= '0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            dig_q   <= dig_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            rnd_q   <= rnd_d;
        end
    end

    assign bus.start_ready  = (state_q == IDLE);
    assign bus.m_ready      = (state_q == WAIT_BYTE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.digest_out   = dig_q;
    assign bus.digest_valid = dv_q;
endmodule

// File: tb/tb_full_hash_des_sbox_stream.sv
// Randomized self-checking bench for full_hash_des_sbox_stream against a table-driven reference model.
module tb_full_hash_des_sbox_stream;
    localparam logic [31:0] H_INIT = 32'h4B71DF03;
    localparam int          ROUNDS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    full_hash_des_sbox_stream_if #(.CNT_W(64)) bus ();
    full_hash_des_sbox_stream_if #(.CNT_W(64)) bus_u4 ();

    full_hash_des_sbox_stream #(.ROUNDS(4), .UNROLL(1), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    full_hash_des_sbox_stream #(.ROUNDS(4), .UNROLL(4), .CNT_W(64)) dut_u4 (
        .clk(clk), .rst(rst), .bus(bus_u4)
    );

    int errors = 0;
    int checks = 0;

    int sbox5 [64] = '{
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3
    };

    function automatic int bit_of(int v, int k);
        return (v >> k) & 1;
    endfunction

    function automatic int sbox_ref(int v);
        int row, col;
        row = 2 * bit_of(v, 5) + bit_of(v, 0);
        col = (v >> 1) & 15;
        return sbox5[16 * row + col];
    endfunction

    function automatic int m6_ref(int m);
        return ((bit_of(m, 3) ^ bit_of(m, 2)) << 5) | (bit_of(m, 1) << 4) | (bit_of(m, 0) << 3)
             | (bit_of(m, 7) << 2) | (bit_of(m, 6) << 1) | (bit_of(m, 5) ^ bit_of(m, 4));
    endfunction

    function automatic int c6_ref(int c);
        return ((bit_of(c, 7) ^ bit_of(c, 1)) << 5) | (bit_of(c, 3) << 4) | (bit_of(c, 2) << 3)
             | ((bit_of(c, 5) ^ bit_of(c, 0)) << 2) | (bit_of(c, 4) << 1) | bit_of(c, 6);
    endfunction

    function automatic int rot_ref(int x, int n);
        return ((x << n) | (x >> (4 - n))) & 15;
    endfunction

    function automatic logic [31:0] model_digest(input logic [31:0] iv, input logic [7:0] msg[$],
                                                 input longint unsigned len);
        int h [8];
        int nh [8];
        int s, c;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) h[i] = int'((iv >> (4 * i)) & 32'hF);
        foreach (msg[k]) begin
            s = sbox_ref(m6_ref(int'(msg[k])));
            for (int r_i = 0; r_i < ROUNDS; r_i++) begin
                for (int i = 0; i < 8; i++) nh[i] = rot_ref(h[(i + 1) % 8] ^ s, i / 2);
                h = nh;
            end
        end
        for (int i = 0; i < 8; i++) begin
            c = int'((len >> (8 * i)) & 64'hFF);
            nh[i] = rot_ref(h[(i + 1) % 8] ^ sbox_ref(c6_ref(c)), i / 2);
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[4 * i +: 4] = nh[i][3:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.digest_ready = 1'b1;
        tick();
        bus.digest_ready = 1'b0;
    endtask

    // Drives one message on the main instance; lat counts cycles from the start cycle to digest_valid
    task automatic send_msg(input longint unsigned len, input logic [7:0] msg[$], input int gap_max,
                            input bit extra, output int lat, output int acc, output int mr_cycles,
                            output bit done);
        int idx, gap;
        idx = 0; gap = 0; lat = 0; acc = 0; mr_cycles = 0; done = 1'b0;
        bus.start   = 1'b1;
        bus.msg_len = len;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (gap > 0) begin
                bus.m_valid = 1'b0;
                gap--;
            end else if (idx < msg.size()) begin
                bus.m_valid = 1'b1;
                bus.m_data  = msg[idx];
            end else begin
                bus.m_valid = extra ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.m_data  = 8'($urandom);
            end
            if (bus.m_ready) mr_cycles++;
            if (bus.m_ready && bus.m_valid) begin
                acc++;
                idx++;
                gap = int'($urandom_range(gap_max, 0));
            end
            tick();
            lat++;
            bus.start = 1'b0;
            if (bus.digest_valid) done = 1'b1;
        end
        bus.m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got=%b exp=0", bus.m_ready); end
        checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid got=%b exp=0", bus.digest_valid); end
        checks++; if (bus.digest_out !== 32'h0) begin errors++; $display("FAIL reset_digest_out got=%h exp=0", bus.digest_out); end
        checks++; if (bus_u4.start_ready !== 1'b1) begin errors++; $display("FAIL reset_u4_start_ready got=%b exp=1", bus_u4.start_ready); end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        logic [7:0] msg[$];
        int lat, acc, mr;
        bit done;
        send_msg(0, msg, 0, 1'b0, lat, acc, mr, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_timeout got=%b exp=1", done); end
        checks++; if (lat != 2) begin errors++; $display("FAIL empty_latency got=%0d exp=2", lat); end
        checks++; if (bus.digest_out !== 32'h83656FD2) begin errors++; $display("FAIL empty_digest got=%h exp=83656fd2", bus.digest_out); end
        checks++; if (bus.digest_out !== model_digest(H_INIT, msg, 0)) begin errors++; $display("FAIL empty_model got=%h exp=%h", bus.digest_out, model_digest(H_INIT, msg, 0)); end
        checks++; if (mr != 0) begin errors++; $display("FAIL empty_m_ready_cycles got=%0d exp=0", mr); end
        drain();
    endtask

    task automatic test_single_zero();
        logic [7:0] msg[$];
        int lat, acc, mr;
        bit done;
        msg.push_back(8'h00);
        send_msg(1, msg, 0, 1'b0, lat, acc, mr, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_timeout got=%b exp=1", done); end
        checks++; if (lat != 1 + (1 + ROUNDS) + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, 1 + (1 + ROUNDS) + 1); end
        checks++; if (bus.digest_out !== 32'h561BBAAF) begin errors++; $display("FAIL single_digest got=%h exp=561bbaaf", bus.digest_out); end
        checks++; if (bus.digest_out !== model_digest(H_INIT, msg, 1)) begin errors++; $display("FAIL single_model got=%h exp=%h", bus.digest_out, model_digest(H_INIT, msg, 1)); end
        checks++; if (acc != 1) begin errors++; $display("FAIL single_accepted got=%0d exp=1", acc); end
        checks++; if (mr != 1) begin errors++; $display("FAIL single_m_ready_cycles got=%0d exp=1", mr); end
        drain();
    endtask

    task automatic test_unroll();
        int lat;
        bit done;
        lat = 0; done = 1'b0;
        bus_u4.start   = 1'b1;
        bus_u4.msg_len = 64'd1;
        bus_u4.m_valid = 1'b1;
        bus_u4.m_data  = 8'h00;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            tick();
            lat++;
            bus_u4.start = 1'b0;
            if (bus_u4.digest_valid) done = 1'b1;
        end
        bus_u4.m_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL unroll_timeout got=%b exp=1", done); end
        checks++; if (lat != 4) begin errors++; $display("FAIL unroll_latency got=%0d exp=4", lat); end
        checks++; if (bus_u4.digest_out !== 32'h561BBAAF) begin errors++; $display("FAIL unroll_digest got=%h exp=561bbaaf", bus_u4.digest_out); end
        bus_u4.digest_ready = 1'b1;
        tick();
        bus_u4.digest_ready = 1'b0;
        checks++; if (bus_u4.start_ready !== 1'b1) begin errors++; $display("FAIL unroll_idle got=%b exp=1", bus_u4.start_ready); end
    endtask

    task automatic test_gapped();
        logic [7:0] msg[$];
        logic [31:0] dig_plain, exp;
        int lat, acc, mr;
        bit done;
        for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
        exp = model_digest(H_INIT, msg, 3);
        send_msg(3, msg, 0, 1'b0, lat, acc, mr, done);
        dig_plain = bus.digest_out;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gapless_timeout got=%b exp=1", done); end
        checks++; if (lat != 1 + 3 * (1 + ROUNDS) + 1) begin errors++; $display("FAIL gapless_latency got=%0d exp=%0d", lat, 1 + 3 * (1 + ROUNDS) + 1); end
        checks++; if (dig_plain !== exp) begin errors++; $display("FAIL gapless_model got=%h exp=%h", dig_plain, exp); end
        drain();
        send_msg(3, msg, 5, 1'b1, lat, acc, mr, done);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gapped_timeout got=%b exp=1", done); end
        checks++; if (bus.digest_out !== exp) begin errors++; $display("FAIL gapped_digest got=%h exp=%h", bus.digest_out, exp); end
        checks++; if (acc != 3) begin errors++; $display("FAIL gapped_accepted got=%0d exp=3", acc); end
        drain();
    endtask

    task automatic test_random();
        logic [7:0] msg[$];
        logic [31:0] exp;
        int lat, acc, mr, len;
        bit done;
        for (int t = 0; t < 5; t++) begin
            msg.delete();
            len = int'($urandom_range(6, 1));
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            exp = model_digest(H_INIT, msg, longint'(len));
            send_msg(longint'(len), msg, 3, 1'b1, lat, acc, mr, done);
            checks++; if (bus.digest_out !== exp || done !== 1'b1) begin errors++; $display("FAIL random_digest[%0d] got=%h exp=%h done=%b", t, bus.digest_out, exp, done); end
            checks++; if (acc != len) begin errors++; $display("FAIL random_accepted[%0d] got=%0d exp=%0d", t, acc, len); end
            drain();
        end
    endtask

    task automatic test_hold();
        logic [7:0] msg[$];
        logic [31:0] held;
        int lat, acc, mr;
        bit done;
        msg.push_back(8'($urandom));
        msg.push_back(8'($urandom));
        send_msg(2, msg, 0, 1'b0, lat, acc, mr, done);
        held = bus.digest_out;
        checks++; if (held !== model_digest(H_INIT, msg, 2) || done !== 1'b1) begin errors++; $display("FAIL hold_digest got=%h exp=%h", held, model_digest(H_INIT, msg, 2)); end
        for (int c = 0; c < 10; c++) begin
            bus.start   = 1'($urandom_range(1, 0));
            bus.msg_len = 64'($urandom_range(3, 0));
            tick();
            checks++; if (bus.digest_valid !== 1'b1 || bus.digest_out !== held) begin errors++; $display("FAIL hold_stable[%0d] got=%b/%h exp=1/%h", c, bus.digest_valid, bus.digest_out, held); end
            checks++; if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold_start_ready[%0d] got=%b busy=%b exp=0 busy=1", c, bus.start_ready, bus.busy); end
        end
        bus.start        = 1'b1;
        bus.msg_len      = 64'd0;
        bus.digest_ready = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.digest_ready = 1'b0;
        checks++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL release_idle got=%b busy=%b exp=1 busy=0", bus.start_ready, bus.busy); end
        checks++; if (bus.digest_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", bus.digest_valid); end
        checks++; if (bus.digest_out !== held) begin errors++; $display("FAIL release_digest_kept got=%h exp=%h", bus.digest_out, held); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_start_ignored got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] msg[$];
        int lat, acc, mr;
        bit done;
        bus.start   = 1'b1;
        bus.msg_len = 64'd5;
        bus.m_valid = 1'b1;
        bus.m_data  = 8'($urandom);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.m_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.m_ready !== 1'b0) begin errors++; $display("FAIL midround_state got busy=%b m_ready=%b exp busy=1 m_ready=0", bus.busy, bus.m_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL midrst_start_ready got=%b exp=1", bus.start_ready); end
        checks++; if (bus.busy !== 1'b0 || bus.m_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b m_ready=%b exp=0", bus.busy, bus.m_ready); end
        checks++; if (bus.digest_valid !== 1'b0 || bus.digest_out !== 32'h0) begin errors++; $display("FAIL midrst_digest got=%b/%h exp=0/0", bus.digest_valid, bus.digest_out); end
        send_msg(0, msg, 0, 1'b0, lat, acc, mr, done);
        checks++; if (bus.digest_out !== 32'h83656FD2 || done !== 1'b1) begin errors++; $display("FAIL after_rst_digest got=%h exp=83656fd2", bus.digest_out); end
        drain();
    endtask

    initial begin
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.msg_len         = '0;
        bus.m_valid         = 1'b0;
        bus.m_data          = '0;
        bus.digest_ready    = 1'b0;
        bus_u4.start        = 1'b0;
        bus_u4.msg_len      = '0;
        bus_u4.m_valid      = 1'b0;
        bus_u4.m_data       = '0;
        bus_u4.digest_ready = 1'b0;
`ifdef FULL_HASH_IV_LOAD_EN
        bus.iv    = H_INIT;
        bus_u4.iv = H_INIT;
`endif
        test_reset();
        test_empty();
        test_single_zero();
        test_unroll();
        test_gapped();
        test_random();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
